// File: rtl/status_register_unit_pkg.sv
// rtl/status_register_unit_pkg.sv - NZCV flag ordering shared by the status register and condition checker
package status_register_unit_pkg;

   // Bit positions inside the packed {N,Z,C,V} flag word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] flags_t;

endpackage

// File: rtl/status_register_unit_sat_counter.sv
// rtl/status_register_unit_sat_counter.sv - saturating up-counter with sync reset
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Stops at all-ones so a long run never wraps back to a small value
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/status_register_unit.sv
// rtl/status_register_unit.sv - architectural NZCV register with EXE-to-ID bypass and update counter
module status_register_unit
   import status_register_unit_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             exe_valid,
   input  logic             exe_s,
   input  logic             exe_cond_pass,
   input  logic [3:0]       alu_status,
   output logic [3:0]       sr_q,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             sr_wr,
   output logic [CNT_W-1:0] upd_cnt
);

   logic   wr_en;
   flags_t sr_d;
   logic   sr_wr_q;
   logic   sr_wr_d;
   flags_t flags_id;

   assign wr_en = exe_valid & exe_s & exe_cond_pass & ~freeze & ~flush;

   // alu_status is only ever selected under wr_en, so garbage on it stays out of state
   always_comb begin
      sr_d    = sr_q;
      sr_wr_d = wr_en;
      if (wr_en) begin
         sr_d = alu_status;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q    <= '0;
         sr_wr_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         sr_wr_q <= sr_wr_d;
      end
   end

   always_comb begin
      flags_id = sr_q;
      if (BYPASS_EN && wr_en) begin
         flags_id = alu_status;
      end
   end

   assign N     = flags_id[FLAG_N];
   assign Z     = flags_id[FLAG_Z];
   assign C     = flags_id[FLAG_C];
   assign V     = flags_id[FLAG_V];
   assign sr_wr = sr_wr_q;

   sat_counter #(
      .W (CNT_W)
   ) u_upd_cnt (
      .clk (clk),
      .rst (rst),
      .inc (wr_en),
      .cnt (upd_cnt)
   );

endmodule
